// File: rtl/noc_traffic_node.sv
// NoC traffic node: a packet generator on the outbound channel and a
// pattern checker on the inbound channel. The two sides share no state.
module noc_traffic_node #(
  parameter int X_ID   = 0,
  parameter int Y_ID   = 0,
  parameter int IDW    = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              noc_clk,
  input  logic              noc_rst_n,
  input  logic              receive_valid,
  output logic              receive_ready,
  input  logic [DATA_W-1:0] receive_flit,
  input  logic              receive_is_header,
  input  logic              receive_is_tail,
  output logic              sender_valid,
  input  logic              sender_ready,
  output logic [DATA_W-1:0] sender_flit,
  output logic              sender_is_header,
  output logic              sender_is_tail,
  input  logic              gen_en,
  input  logic [IDW-1:0]    gen_dst_x,
  input  logic [IDW-1:0]    gen_dst_y,
  input  logic [7:0]        gen_len,
  input  logic [CNT_W-1:0]  gen_pkt_num,
  input  logic [7:0]        gen_gap,
  input  logic              rx_hold,
  output logic              gen_done,
  output logic [CNT_W-1:0]  tx_pkt_cnt,
  output logic [CNT_W-1:0]  rx_pkt_cnt,
  output logic [CNT_W-1:0]  rx_err_cnt,
  output logic              rx_err
);

  localparam logic [IDW-1:0]   SRC_X   = IDW'(X_ID);
  localparam logic [IDW-1:0]   SRC_Y   = IDW'(Y_ID);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, HEAD, BODY, GAP, DONE} tx_state_t;
  typedef enum logic {R_HEAD, R_BODY} rx_state_t;

  function automatic logic [DATA_W-1:0] mk_head(input logic [IDW-1:0] dx, input logic [IDW-1:0] dy,
                                                input logic [7:0] len, input logic [7:0] seq);
    logic [DATA_W-1:0] f;
    f = '0;
    f[DATA_W-1 -: IDW]         = dx;
    f[DATA_W-1-IDW -: IDW]     = dy;
    f[DATA_W-1-2*IDW -: IDW]   = SRC_X;
    f[DATA_W-1-3*IDW -: IDW]   = SRC_Y;
    f[15:8]                    = len;
    f[7:0]                     = seq;
    return f;
  endfunction

  function automatic logic [DATA_W-1:0] mk_body(input logic [IDW-1:0] sx, input logic [IDW-1:0] sy,
                                                input logic [7:0] seq, input logic [7:0] k);
    logic [DATA_W-1:0] f;
    f = '0;
    f[DATA_W-1 -: IDW]       = sx;
    f[DATA_W-1-IDW -: IDW]   = sy;
    f[DATA_W-1-2*IDW -: 8]   = seq;
    f[DATA_W-9-2*IDW -: 8]   = k;
    return f;
  endfunction

  // ---------------- sender ----------------
  tx_state_t         state, state_n;
  logic [7:0]        seq, k, k_n, gap_cnt, gap_cnt_n;
  logic [IDW-1:0]    dst_x_q, dst_y_q;
  logic [7:0]        len_q, gap_q, eff_len;
  logic [CNT_W-1:0]  pkt_num_q, pkts_sent, sent_inc;
  logic              fire, ld_cfg, ld_out, pkt_end;
  logic              v_n, h_n, t_n;
  logic [DATA_W-1:0] f_n;

  assign fire     = sender_valid && sender_ready;
  assign eff_len  = (len_q == 8'd0) ? 8'd1 : len_q;
  assign sent_inc = pkts_sent + CNT_W'(1);

  // Sender next-state and next registered flit; outputs only reload on ld_out
  always_comb begin
    state_n   = state;
    k_n       = k;
    gap_cnt_n = gap_cnt;
    ld_cfg    = 1'b0;
    ld_out    = 1'b0;
    pkt_end   = 1'b0;
    v_n       = 1'b0;
    h_n       = 1'b0;
    t_n       = 1'b0;
    f_n       = '0;
    gen_done  = 1'b0;
    case (state)
      IDLE: if (gen_en) begin
        state_n = HEAD;
        ld_cfg  = 1'b1;
        ld_out  = 1'b1;
        v_n     = 1'b1;
        h_n     = 1'b1;
        f_n     = mk_head(gen_dst_x, gen_dst_y, gen_len, seq);
      end
      HEAD: if (fire) begin
        state_n = BODY;
        k_n     = 8'd1;
        ld_out  = 1'b1;
        v_n     = 1'b1;
        t_n     = (eff_len == 8'd1);
        f_n     = mk_body(SRC_X, SRC_Y, seq, 8'd1);
      end
      BODY: if (fire) begin
        ld_out = 1'b1;
        if (sender_is_tail) begin
          pkt_end = 1'b1;
          if (pkt_num_q != '0 && sent_inc == pkt_num_q) begin
            state_n = DONE;
          end else if (gap_q != 8'd0) begin
            state_n   = GAP;
            gap_cnt_n = 8'd0;
          end else begin
            state_n = HEAD;
            v_n     = 1'b1;
            h_n     = 1'b1;
            f_n     = mk_head(dst_x_q, dst_y_q, len_q, seq + 8'd1);
          end
        end else begin
          k_n = k + 8'd1;
          v_n = 1'b1;
          t_n = ((k + 8'd1) == eff_len);
          f_n = mk_body(SRC_X, SRC_Y, seq, k + 8'd1);
        end
      end
      GAP: begin
        if (!gen_en) begin
          state_n = IDLE;
        end else if (gap_cnt == gap_q - 8'd1) begin
          state_n = HEAD;
          ld_out  = 1'b1;
          v_n     = 1'b1;
          h_n     = 1'b1;
          f_n     = mk_head(dst_x_q, dst_y_q, len_q, seq);
        end else begin
          gap_cnt_n = gap_cnt + 8'd1;
        end
      end
      DONE: begin
        gen_done = 1'b1;
        if (!gen_en) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Sender state, config latch, registered outbound flit and counters
  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) begin
      state            <= IDLE;
      seq              <= '0;
      k                <= '0;
      gap_cnt          <= '0;
      dst_x_q          <= '0;
      dst_y_q          <= '0;
      len_q            <= '0;
      gap_q            <= '0;
      pkt_num_q        <= '0;
      pkts_sent        <= '0;
      tx_pkt_cnt       <= '0;
      sender_valid     <= 1'b0;
      sender_flit      <= '0;
      sender_is_header <= 1'b0;
      sender_is_tail   <= 1'b0;
    end else begin
      state   <= state_n;
      k       <= k_n;
      gap_cnt <= gap_cnt_n;
      if (ld_cfg) begin
        dst_x_q   <= gen_dst_x;
        dst_y_q   <= gen_dst_y;
        len_q     <= gen_len;
        gap_q     <= gen_gap;
        pkt_num_q <= gen_pkt_num;
        pkts_sent <= '0;
      end
      if (pkt_end) begin
        seq <= seq + 8'd1;
        if (pkts_sent != CNT_MAX)  pkts_sent  <= sent_inc;
        if (tx_pkt_cnt != CNT_MAX) tx_pkt_cnt <= tx_pkt_cnt + CNT_W'(1);
      end
      if (ld_out) begin
        sender_valid     <= v_n;
        sender_flit      <= f_n;
        sender_is_header <= h_n;
        sender_is_tail   <= t_n;
      end
    end
  end

  // ---------------- receive checker ----------------
  rx_state_t        rstate, rstate_n;
  logic [IDW-1:0]   rsrc_x, rsrc_y;
  logic [7:0]       rseq, rlen, rk, hdr_len;
  logic             rpkt_err, rfire, hdr_ok, body_ok, exp_tail;
  logic             bad, take_hdr, pkt_close, advance;

  assign receive_ready = ~rx_hold;
  assign rfire    = receive_valid && receive_ready;
  assign hdr_len  = receive_flit[15:8];
  assign hdr_ok   = receive_is_header &&
                    receive_flit[DATA_W-1 -: IDW] == SRC_X &&
                    receive_flit[DATA_W-1-IDW -: IDW] == SRC_Y;
  assign exp_tail = (rk == rlen);
  assign body_ok  = (receive_flit == mk_body(rsrc_x, rsrc_y, rseq, rk)) &&
                    (receive_is_tail == exp_tail);

  // Checker next-state: classify each accepted flit
  always_comb begin
    rstate_n  = rstate;
    bad       = 1'b0;
    take_hdr  = 1'b0;
    pkt_close = 1'b0;
    advance   = 1'b0;
    if (rfire) begin
      case (rstate)
        R_HEAD: begin
          if (hdr_ok) begin
            take_hdr = 1'b1;
            rstate_n = R_BODY;
          end else begin
            bad = 1'b1;
          end
        end
        R_BODY: begin
          if (receive_is_header) begin
            // Truncated packet: flag once, then treat the flit as a fresh header
            bad = 1'b1;
            if (hdr_ok) take_hdr = 1'b1;
            else        rstate_n = R_HEAD;
          end else begin
            bad = !body_ok;
            if (receive_is_tail || exp_tail) begin
              pkt_close = 1'b1;
              rstate_n  = R_HEAD;
            end else begin
              advance = 1'b1;
            end
          end
        end
        default: rstate_n = R_HEAD;
      endcase
    end
  end

  // Checker state, latched header fields and error/packet statistics
  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) begin
      rstate     <= R_HEAD;
      rsrc_x     <= '0;
      rsrc_y     <= '0;
      rseq       <= '0;
      rlen       <= '0;
      rk         <= '0;
      rpkt_err   <= 1'b0;
      rx_pkt_cnt <= '0;
      rx_err_cnt <= '0;
      rx_err     <= 1'b0;
    end else begin
      rstate <= rstate_n;
      if (take_hdr) begin
        rsrc_x   <= receive_flit[DATA_W-1-2*IDW -: IDW];
        rsrc_y   <= receive_flit[DATA_W-1-3*IDW -: IDW];
        rseq     <= receive_flit[7:0];
        rlen     <= (hdr_len == 8'd0) ? 8'd1 : hdr_len;
        rk       <= 8'd1;
        rpkt_err <= 1'b0;
      end else if (advance) begin
        rk       <= rk + 8'd1;
        rpkt_err <= rpkt_err | bad;
      end
      if (pkt_close && !(rpkt_err || bad) && rx_pkt_cnt != CNT_MAX)
        rx_pkt_cnt <= rx_pkt_cnt + CNT_W'(1);
      if (bad) begin
        rx_err <= 1'b1;
        if (rx_err_cnt != CNT_MAX) rx_err_cnt <= rx_err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_noc_traffic_node.sv
// Scoreboard bench for noc_traffic_node: generated packets are looped back
// into the checker, plus hand-injected flits for receive error cases.
module tb_noc_traffic_node;
  localparam int DATA_W = 32;
  localparam int IDW    = 4;
  localparam int CNT_W  = 16;

  logic noc_clk = 1'b0;
  logic noc_rst_n = 1'b0;
  always #5 noc_clk = ~noc_clk;

  logic              receive_valid, receive_ready, receive_is_header, receive_is_tail;
  logic [DATA_W-1:0] receive_flit;
  logic              sender_valid, sender_ready, sender_is_header, sender_is_tail;
  logic [DATA_W-1:0] sender_flit;
  logic              gen_en, rx_hold, gen_done, rx_err;
  logic [IDW-1:0]    gen_dst_x, gen_dst_y;
  logic [7:0]        gen_len, gen_gap;
  logic [CNT_W-1:0]  gen_pkt_num, tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt;

  logic              loop;
  logic              inj_valid, inj_hdr, inj_tail;
  logic [DATA_W-1:0] inj_flit;

  assign receive_valid     = loop ? (sender_valid && sender_ready) : inj_valid;
  assign receive_flit      = loop ? sender_flit      : inj_flit;
  assign receive_is_header = loop ? sender_is_header : inj_hdr;
  assign receive_is_tail   = loop ? sender_is_tail   : inj_tail;

  noc_traffic_node #(.X_ID(0), .Y_ID(0), .IDW(IDW), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
    .receive_valid(receive_valid), .receive_ready(receive_ready), .receive_flit(receive_flit),
    .receive_is_header(receive_is_header), .receive_is_tail(receive_is_tail),
    .sender_valid(sender_valid), .sender_ready(sender_ready), .sender_flit(sender_flit),
    .sender_is_header(sender_is_header), .sender_is_tail(sender_is_tail),
    .gen_en(gen_en), .gen_dst_x(gen_dst_x), .gen_dst_y(gen_dst_y), .gen_len(gen_len),
    .gen_pkt_num(gen_pkt_num), .gen_gap(gen_gap), .rx_hold(rx_hold),
    .gen_done(gen_done), .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt),
    .rx_err_cnt(rx_err_cnt), .rx_err(rx_err)
  );

  typedef struct packed { logic [DATA_W-1:0] f; logic h; logic t; } flit_t;
  flit_t sb[$];
  int    xfer_cyc[$];
  int    cyc = 0;
  int    n_chk = 0, n_pass = 0;
  int    m_seq = 0, m_tx = 0, m_rx = 0, m_err = 0;
  int    rdy_mode = 0;

  always @(posedge noc_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: expected flit stream and counter effects of one run
  task automatic push_run(input logic [3:0] dx, input logic [3:0] dy, input int len, input int num);
    int eff;
    logic [7:0] s;
    eff = (len == 0) ? 1 : len;
    for (int p = 0; p < num; p++) begin
      s = m_seq[7:0];
      sb.push_back('{f: {dx, dy, 4'h0, 4'h0, 8'(len), s}, h: 1'b1, t: 1'b0});
      for (int k = 1; k <= eff; k++)
        sb.push_back('{f: {4'h0, 4'h0, s, 8'(k), 8'h00}, h: 1'b0, t: (k == eff)});
      m_seq = (m_seq + 1) % 256;
    end
    m_tx += num;
    if (dx == 0 && dy == 0) m_rx += num;
    else m_err += num * (1 + eff);
  endtask

  // Monitor: pops the scoreboard on every outbound transfer, checks stall hold
  initial begin
    logic  prev_stall;
    flit_t prev_out, e;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge noc_clk);
      if (noc_rst_n) begin
        if (prev_stall)
          chk("stall_hold", {sender_valid, sender_flit, sender_is_header, sender_is_tail},
              {1'b1, prev_out});
        if (sender_valid && sender_ready) begin
          if (sb.size() == 0) chk("sb_empty_on_xfer", sb.size(), 1);
          else begin
            e = sb.pop_front();
            chk("flit", {sender_flit, sender_is_header, sender_is_tail}, e);
          end
          xfer_cyc.push_back(cyc);
        end
        prev_stall = sender_valid && !sender_ready;
        prev_out   = '{f: sender_flit, h: sender_is_header, t: sender_is_tail};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Outbound backpressure pattern
  initial begin
    sender_ready = 1'b1;
    forever begin
      @(posedge noc_clk); #1;
      case (rdy_mode)
        0:       sender_ready = 1'b1;
        1:       sender_ready = ~sender_ready;
        default: sender_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic tick();
    @(posedge noc_clk); #1;
  endtask

  task automatic inj(input logic [DATA_W-1:0] f, input logic h, input logic t);
    inj_flit = f; inj_hdr = h; inj_tail = t; inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_tx"},  tx_pkt_cnt, m_tx);
    chk({tag, "_rx"},  rx_pkt_cnt, m_rx);
    chk({tag, "_err"}, rx_err_cnt, m_err);
  endtask

  task automatic run(input string tag, input logic [3:0] dx, input logic [3:0] dy,
                     input int len, input int num, input int gap);
    push_run(dx, dy, len, num);
    gen_dst_x = dx; gen_dst_y = dy; gen_len = 8'(len);
    gen_pkt_num = CNT_W'(num); gen_gap = 8'(gap); gen_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (gen_done) break;
    end
    chk({tag, "_done"}, gen_done, 1);
    chk_counts(tag);
    gen_en = 1'b0;
    tick(); tick();
    chk({tag, "_done_clr"}, gen_done, 0);
    chk({tag, "_sb_drained"}, sb.size(), 0);
  endtask

  initial begin
    int base;
    loop = 1'b0; inj_valid = 1'b0; inj_hdr = 1'b0; inj_tail = 1'b0; inj_flit = '0;
    gen_en = 1'b0; gen_dst_x = '0; gen_dst_y = '0; gen_len = '0;
    gen_pkt_num = '0; gen_gap = '0; rx_hold = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_valid", sender_valid, 0);
    chk("rst_flit", sender_flit, 0);
    chk("rst_hdr_tail", {sender_is_header, sender_is_tail}, 0);
    chk("rst_done", gen_done, 0);
    chk_counts("rst");
    chk("rst_rx_err", rx_err, 0);
    chk("rst_ready", receive_ready, 1);
    rx_hold = 1'b1; #1;
    chk("hold_ready", receive_ready, 0);
    rx_hold = 1'b0;
    noc_rst_n = 1'b1;
    tick();

    // Wrong destination header
    inj({4'h1, 4'h0, 4'h0, 4'h0, 8'd1, 8'd0}, 1'b1, 1'b0);
    m_err += 1;
    chk_counts("v3");
    chk("v3_rx_err", rx_err, 1);

    // Truncated packet followed by a good packet
    inj({4'h0, 4'h0, 4'h0, 4'h0, 8'd4, 8'd7}, 1'b1, 1'b0);
    inj({4'h0, 4'h0, 8'd7, 8'd1, 8'h00}, 1'b0, 1'b0);
    inj({4'h0, 4'h0, 8'd7, 8'd2, 8'h00}, 1'b0, 1'b0);
    inj({4'h0, 4'h0, 4'h0, 4'h0, 8'd1, 8'd8}, 1'b1, 1'b0);
    inj({4'h0, 4'h0, 8'd8, 8'd1, 8'h00}, 1'b0, 1'b1);
    m_err += 1; m_rx += 1;
    chk_counts("v4");

    // Held receiver ignores a header; the next body then counts as an error
    rx_hold = 1'b1;
    inj({4'h0, 4'h0, 4'h0, 4'h0, 8'd1, 8'd9}, 1'b1, 1'b0);
    chk_counts("hold");
    rx_hold = 1'b0;
    inj({4'h0, 4'h0, 8'd9, 8'd1, 8'h00}, 1'b0, 1'b1);
    m_err += 1;
    chk_counts("hold_rel");

    // Loopback runs
    loop = 1'b1;
    rdy_mode = 0;
    xfer_cyc.delete();
    run("v1", 4'h0, 4'h0, 3, 2, 0);
    chk("v1_xfers", xfer_cyc.size(), 8);
    if (xfer_cyc.size() == 8) chk("v1_b2b", xfer_cyc[7] - xfer_cyc[0], 7);

    rdy_mode = 1;
    run("v2", 4'h0, 4'h0, 3, 2, 0);

    rdy_mode = 0;
    run("v5", 4'h0, 4'h0, 0, 1, 0);

    xfer_cyc.delete();
    run("gap", 4'h0, 4'h0, 1, 2, 2);
    if (xfer_cyc.size() == 4) chk("gap_idle", xfer_cyc[2] - xfer_cyc[1], 3);
    else chk("gap_xfers", xfer_cyc.size(), 4);

    rdy_mode = 2;
    for (int r = 0; r < 12; r++) begin
      logic [3:0] dx, dy;
      dx = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      dy = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      run("rnd", dx, dy, $urandom_range(0, 6), $urandom_range(1, 4), $urandom_range(0, 3));
    end

    rdy_mode = 0;
    run("seq_wrap", 4'h0, 4'h0, 0, 260, 0);

    // Reset mid-packet
    push_run(4'h0, 4'h0, 5, 1);
    gen_dst_x = '0; gen_dst_y = '0; gen_len = 8'd5; gen_pkt_num = '0; gen_gap = '0;
    gen_en = 1'b1;
    base = xfer_cyc.size();
    for (int i = 0; i < 100; i++) begin
      tick();
      if (xfer_cyc.size() >= base + 3) break;
    end
    chk("v6_mid_body", xfer_cyc.size() >= base + 3, 1);
    noc_rst_n = 1'b0; gen_en = 1'b0;
    tick();
    sb.delete();
    m_seq = 0; m_tx = 0; m_rx = 0; m_err = 0;
    chk("v6_valid", sender_valid, 0);
    chk_counts("v6_rst");
    chk("v6_rx_err", rx_err, 0);
    noc_rst_n = 1'b1;
    tick();
    run("v6_restart", 4'h0, 4'h0, 2, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/noc_traffic_node.md
NOC_TRAFFIC_NODE -- requirements
Module: noc_traffic_node

Interface
REQ-001 SHALL have parameters: X_ID, default 0, own X coordinate; Y_ID, default 0, own Y coordinate; IDW, default 4, coordinate width; DATA_W, default 32, flit width (DATA_W >= 4*IDW+16); CNT_W, default 16, statistics counter width.
REQ-002 SHALL have ports: noc_clk in 1 clock; noc_rst_n in 1 synchronous active-low reset.
REQ-003 SHALL have ports: receive_valid in 1, receive_ready out 1, receive_flit in DATA_W, receive_is_header in 1, receive_is_tail in 1 -- inbound flit channel.
REQ-004 SHALL have ports: sender_valid out 1, sender_ready in 1, sender_flit out DATA_W, sender_is_header out 1, sender_is_tail out 1 -- outbound flit channel.
REQ-005 SHALL have ports: gen_en in 1, start/continue generation; gen_dst_x in IDW, gen_dst_y in IDW, destination; gen_len in 8, body flits per packet; gen_pkt_num in CNT_W, packets to send (0 = unbounded); gen_gap in 8, idle cycles between packets; rx_hold in 1, force receive_ready low.
REQ-006 SHALL have ports: gen_done out 1; tx_pkt_cnt out CNT_W; rx_pkt_cnt out CNT_W; rx_err_cnt out CNT_W; rx_err out 1, sticky error flag.

Function
REQ-007 Header flit format SHALL be: [DATA_W-1 -: IDW] dst_x, next IDW dst_y, next IDW src_x, next IDW src_y, [15:8] len, [7:0] seq; remaining bits zero.
REQ-008 Body flit k (k = 1..len) SHALL be: top 2*IDW bits {src_x,src_y}, next 8 bits seq, next 8 bits k, all lower bits zero; only flit k = len has is_tail = 1.
REQ-009 gen_len = 0 SHALL be treated as 1.
REQ-010 A transfer SHALL occur on a rising noc_clk edge with valid && ready high; sender_valid, sender_flit, sender_is_header, and sender_is_tail SHALL be registered and held stable while sender_valid = 1 and sender_ready = 0.
REQ-011 The sender FSM SHALL have states IDLE, HEAD, BODY, GAP, DONE.
REQ-012 IDLE -> HEAD SHALL occur when gen_en = 1, latching dst, len, pkt_num, and gap; first header is valid the cycle after the transition.
REQ-013 HEAD -> BODY SHALL occur on header transfer.
REQ-014 BODY SHALL send k = 1..len; on tail transfer, tx_pkt_cnt and seq SHALL increment (seq wraps 255 -> 0), then go to DONE if packets sent = pkt_num (pkt_num != 0), else GAP if gap > 0, else HEAD.
REQ-015 GAP SHALL count gap idle cycles with sender_valid = 0, then go to HEAD; gen_en = 0 observed in GAP or IDLE SHALL return to IDLE (a packet in flight always completes).
REQ-016 DONE SHALL hold gen_done = 1 until gen_en = 0, then go to IDLE; gen_done = 0 in all other states.
REQ-017 receive_ready SHALL be ~rx_hold, combinational.
REQ-018 The receive checker SHALL have states R_HEAD and R_BODY.
REQ-019 In R_HEAD, an accepted flit SHALL be an error if it has no header, or if dst is not {X_ID,Y_ID}; a good header SHALL latch src, seq, and len (0 -> 1), set expected k = 1, and go to R_BODY.
REQ-020 In R_BODY, each accepted flit SHALL be compared with the REQ-008 pattern and the tail expectation; is_header = 1 SHALL be an error and SHALL be re-evaluated as a new header.
REQ-021 A tail, or k reaching len, SHALL return the checker to R_HEAD; rx_pkt_cnt SHALL increment only if the packet had zero errors.
REQ-022 Each erroneous flit SHALL increment rx_err_cnt by exactly 1 and set rx_err.
REQ-023 All counters SHALL saturate at all-ones, with no wrap.
REQ-024 The same-cycle receive and send SHALL be fully independent.

Reset
REQ-025 On noc_rst_n = 0 at a clock edge: all outputs SHALL be 0 except receive_ready (= ~rx_hold); FSMs SHALL go to IDLE and R_HEAD; counters, seq, and rx_err SHALL clear.
REQ-026 Reset mid-packet SHALL abandon the packet, with sender_valid = 0 the next cycle.

Verification
V1: X_ID=Y_ID=0, loopback sender->receive, gen_dst=(0,0), gen_len=3, gen_pkt_num=2, gap=0 -> 8 transfers back-to-back, tx_pkt_cnt=2, rx_pkt_cnt=2, rx_err_cnt=0, gen_done=1.
V2: sender_ready toggling 1/0 each cycle during V1 -> flits unchanged while stalled; same counts.
V3: inject header with dst=(1,0) into node (0,0) -> rx_err_cnt=1, rx_err=1, rx_pkt_cnt=0.
V4: inject header len=4, body k=1,2, then a header -> rx_err_cnt=1, new packet checked normally.
V5: gen_len=0 -> single body flit with k=1, is_tail=1.
V6: noc_rst_n low during BODY, then high -> sender_valid=0, all counters 0, next gen_en restarts with seq=0.
